ls7408_arbiter: RTL

LS7408_ARBITER -- requirements
Module: ls7408_arbiter

---
 rtl/ls7408_arb_pkg.sv | 22 ++
 rtl/ls7408.sv | 18 +
 rtl/ls7408_arbiter.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/ls7408_arb_pkg.sv
// ----------------------------------------------------------------------------
// ls7408_arb_pkg
// Shared definitions for the ls7408 round-robin arbiter: FSM state encoding,
// operand width, requester-index width and the maximum requester count.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
package ls7408_arb_pkg;

  localparam int OPW      = 4;  // operand / result width of one ls7408
  localparam int NREQ_MAX = 4;  // largest legal NREQ
  localparam int IDW      = 2;  // width of a requester index (NREQ_MAX = 4)

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef logic [OPW-1:0] opnd_t;
  typedef logic [IDW-1:0] id_t;

endpackage

// File: rtl/ls7408.sv
// ----------------------------------------------------------------------------
// ls7408
// Quad 2-input AND gate (74LS08 equivalent), purely combinational.
// Ports:
//   a_i [3:0] - input A of the four gates
//   b_i [3:0] - input B of the four gates
//   y_o [3:0] - y_o[k] = a_i[k] & b_i[k]
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module ls7408 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  output logic [3:0] y_o
);

  assign y_o = a_i & b_i;

endmodule

// File: rtl/ls7408_arbiter.sv
// ----------------------------------------------------------------------------
// ls7408_arbiter
// Shares one ls7408 among NREQ requesters. A round-robin pick in IDLE accepts
// one request, its operands are registered, the gate output is registered in
// EXEC, and the result is held in RESP until the consumer takes it.
// Ports:
//   clk, rst_n          - clock, synchronous active-low reset
//   req_valid [NREQ]    - per-requester request
//   req_a/req_b         - 4-bit operands, requester i in bits [4i+3:4i]
//   req_ready [NREQ]    - one-hot accept strobe (IDLE cycle of the accept only)
//   rsp_valid/rsp_id/rsp_y/rsp_ready - result handshake
//   busy                - high whenever the FSM is not in IDLE
//   grant_cnt [8*NREQ]  - saturating per-requester accept counters, present
//                         only when LS7408_ARB_STATS_EN is defined
// Parameter NREQ: number of requesters, legal range 2..NREQ_MAX.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module ls7408_arbiter
  import ls7408_arb_pkg::*;
#(
  parameter int NREQ = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [OPW*NREQ-1:0] req_a,
  input  logic [OPW*NREQ-1:0] req_b,
  output logic [NREQ-1:0]     req_ready,
  output logic                rsp_valid,
  output logic [IDW-1:0]      rsp_id,
  output logic [OPW-1:0]      rsp_y,
  input  logic                rsp_ready,
  output logic                busy
`ifdef LS7408_ARB_STATS_EN
  ,
  output logic [8*NREQ-1:0]   grant_cnt
`endif
);

  state_e state_q, state_d;
  id_t    last_grant_q, last_grant_d;
  id_t    id_q, id_d;
  opnd_t  op_a_q, op_a_d;
  opnd_t  op_b_q, op_b_d;
  opnd_t  y_q, y_d;
  opnd_t  and_y;

  logic   win_found;
  id_t    win_idx;
  id_t    cand;
  logic   accept;

  // The gate sees only the operand registers, never the request bus.
  ls7408 u_and (
    .a_i (op_a_q),
    .b_i (op_b_q),
    .y_o (and_y)
  );

  // Round-robin pick: first valid index strictly after last_grant, wrapping.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path
    // leaves it unassigned and no latch is inferred.
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDW'((int'(last_grant_q) + k) % NREQ);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign accept = (state_q == ST_IDLE) && win_found;

  // Next-state and output logic.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    y_d          = y_q;
    req_ready    = '0;

    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          req_ready[win_idx] = 1'b1;
          last_grant_d       = win_idx;
          id_d               = win_idx;
          // {win_idx, 2'b00} is win_idx * OPW with OPW fixed at 4.
          op_a_d             = req_a[{win_idx, 2'b00} +: OPW];
          op_b_d             = req_b[{win_idx, 2'b00} +: OPW];
          state_d            = ST_EXEC;
        end
      end
      ST_EXEC: begin
        y_d     = and_y;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state is written with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= IDW'(NREQ - 1);  // requester 0 wins first
      id_q         <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      y_q          <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      y_q          <= y_d;
    end
  end

  assign rsp_valid = (state_q == ST_RESP);
  assign busy      = (state_q != ST_IDLE);
  assign rsp_id    = id_q;
  assign rsp_y     = y_q;

`ifdef LS7408_ARB_STATS_EN
  logic [7:0] cnt_q [NREQ];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the counter array is plain flops, not a RAM, so it is cleared
      // element by element on reset like any other register.
      for (int i = 0; i < NREQ; i++) cnt_q[i] <= '0;
    end else if (accept && (cnt_q[win_idx] != 8'hFF)) begin
      cnt_q[win_idx] <= cnt_q[win_idx] + 8'd1;
    end
  end

  for (genvar g = 0; g < NREQ; g++) begin : g_cnt
    assign grant_cnt[8*g +: 8] = cnt_q[g];
  end
`endif

endmodule
